// File: rtl/branch_resolve_unit.sv
// Purpose: EX-stage branch/jump resolution with PC redirect, wrong-path flush and perf counters.
// Latency: taken decision in cycle N, PCSel_o/flush_o/pc_target_o/illegal_o visible in cycle N+1.
// Backpressure: stall_i freezes the FSM and flush countdown; stalled EX instructions are not accepted.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   valid_i, is_branch_i, is_jump_i   EX instruction qualifiers
//   funct3_i, BrEq_i, BrLt_i          branch condition inputs / comparator flags
//   target_i                          computed redirect target
//   stall_i                           pipeline stall
//   BrUn_o                            unsigned-compare select to the comparator
//   PCSel_o, pc_target_o, flush_o     redirect and flush controls
//   busy_o, illegal_o                 status
//   branch_cnt_o, taken_cnt_o         saturating performance counters
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             is_branch_i,
  input  logic             is_jump_i,
  input  logic [2:0]       funct3_i,
  input  logic             BrEq_i,
  input  logic             BrLt_i,
  input  logic [XLEN-1:0]  target_i,
  input  logic             stall_i,
  output logic             BrUn_o,
  output logic             PCSel_o,
  output logic [XLEN-1:0]  pc_target_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_flush_cnt;
  logic             r_pcsel;
  logic             r_flush;
  logic             r_busy;
  logic             r_illegal;
  logic [XLEN-1:0]  r_target;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_cond;
  logic w_taken;
  logic w_accept;
  logic w_is_br;
  logic w_illegal_f3;

  // Only the unsigned compares need the comparator in unsigned mode.
  assign BrUn_o = (funct3_i == 3'b110) || (funct3_i == 3'b111);

  always_comb begin
    w_cond = 1'b0;
    case (funct3_i)
      3'b000:  w_cond = BrEq_i;
      3'b001:  w_cond = !BrEq_i;
      3'b100:  w_cond = BrLt_i;
      3'b101:  w_cond = !BrLt_i;
      3'b110:  w_cond = BrLt_i;
      3'b111:  w_cond = !BrLt_i;
      default: w_cond = 1'b0;
    endcase
  end

  // A jump wins over a simultaneous branch flag, so funct3 is irrelevant then.
  assign w_is_br      = is_branch_i && !is_jump_i;
  assign w_taken      = valid_i && (is_jump_i || (is_branch_i && w_cond));
  assign w_accept     = valid_i && !stall_i && (is_branch_i || is_jump_i) && (r_state == IDLE);
  assign w_illegal_f3 = (funct3_i == 3'b010) || (funct3_i == 3'b011);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_flush_cnt  <= 4'd0;
      r_pcsel      <= 1'b0;
      r_flush      <= 1'b0;
      r_busy       <= 1'b0;
      r_illegal    <= 1'b0;
      r_target     <= '0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_illegal <= w_accept && w_is_br && w_illegal_f3;

      if (w_accept && w_is_br && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_accept && w_taken && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept && w_taken) begin
            r_state     <= REDIRECT;
            r_target    <= target_i;
            r_flush_cnt <= FLUSH_LOAD;
            r_pcsel     <= 1'b1;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        REDIRECT: begin
          // The redirect cycle is itself the first flush cycle, hence the
          // decrement on the way into FLUSH.
          if (!stall_i) begin
            r_pcsel <= 1'b0;
            if (r_flush_cnt != 4'd0) begin
              r_state     <= FLUSH;
              r_flush_cnt <= r_flush_cnt - 4'd1;
            end else begin
              r_state <= IDLE;
              r_flush <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (!stall_i) begin
            if (r_flush_cnt == 4'd0) begin
              r_state <= IDLE;
              r_flush <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_flush_cnt <= r_flush_cnt - 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_pcsel <= 1'b0;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign PCSel_o      = r_pcsel;
  assign flush_o      = r_flush;
  assign busy_o       = r_busy;
  assign illegal_o    = r_illegal;
  assign pc_target_o  = r_target;
  assign branch_cnt_o = r_branch_cnt;
  assign taken_cnt_o  = r_taken_cnt;

endmodule
